// File: rtl/uart_pkg.sv
// Shared UART types: FSM states, parity/stop encodings and the stop-length helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_RSVD = 2'b11   // behaves as no parity
  } parity_t;

  typedef enum logic [1:0] {
    STOP_1   = 2'b00,
    STOP_1P5 = 2'b01,
    STOP_2   = 2'b10,
    STOP_2X  = 2'b11   // behaves as two stop bits
  } stop_t;

  // Stop-bit length in baud ticks for a given stop mode.
  function automatic int unsigned stop_ticks(stop_t mode, int unsigned os);
    case (mode)
      STOP_1:   return os;
      STOP_1P5: return (3 * os) / 2;
      default:  return 2 * os;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick divider: one tick every dvsr+1 clocks while enabled, counter parked at 0 otherwise.
module uart_baud_gen #(
  parameter int unsigned DVSR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DVSR_W-1:0] dvsr,
  output logic              tick
);

  logic [DVSR_W-1:0] r_cnt;

  assign tick = en && (r_cnt == dvsr);

  // Count 0..dvsr and wrap; held at 0 when disabled so the first tick is a full period away.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      r_cnt <= '0;
    end else if (r_cnt == dvsr) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with valid/ready input and registered serial output.
// Optional line-break generation is compiled in with UART_TX_BREAK_EN.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DVSR_W     = 11
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef UART_TX_BREAK_EN
  input  logic              brk,
`endif
  input  logic [DVSR_W-1:0] dvsr,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DBIT-1:0]   tx_data,
  input  logic [1:0]        parity_mode,
  input  logic [1:0]        stop_mode,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done_tick
);

  localparam int unsigned SW = $clog2(2 * OVERSAMPLE);
  localparam int unsigned NW = $clog2(DBIT);

  state_t          r_state, w_state_n;
  logic [SW-1:0]   r_s, w_s_n;
  logic [NW-1:0]   r_n, w_n_n;
  logic [DBIT-1:0] r_shreg, w_shreg_n;
  logic [DBIT-1:0] r_data, w_data_n;
  parity_t         r_par, w_par_n;
  stop_t           r_stop, w_stop_n;
  logic            r_brk_stop, w_brk_stop_n;
  logic            r_tx, w_tx_n;
  logic            r_busy;
  logic            r_done, w_done_n;

  logic            w_tick;
  logic            w_baud_en;
  logic            w_par_bit;
  logic            w_bit_last;
  logic            w_stop_last;

  assign w_baud_en   = (r_state == START) || (r_state == DATA) ||
                       (r_state == PARITY) || (r_state == STOP);
  assign w_par_bit   = (r_par == PAR_EVEN) ? ^r_data : ~^r_data;
  assign w_bit_last  = (r_s == SW'(OVERSAMPLE - 1));
  assign w_stop_last = (r_s == SW'(stop_ticks(r_stop, OVERSAMPLE) - 1));

  uart_baud_gen #(
    .DVSR_W(DVSR_W)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (w_baud_en),
    .dvsr (dvsr),
    .tick (w_tick)
  );

  // Next-state, datapath and next-output computation.
  always_comb begin
    w_state_n    = r_state;
    w_s_n        = r_s;
    w_n_n        = r_n;
    w_shreg_n    = r_shreg;
    w_data_n     = r_data;
    w_par_n      = r_par;
    w_stop_n     = r_stop;
    w_brk_stop_n = r_brk_stop;
    w_done_n     = 1'b0;

    case (r_state)
      IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (brk) begin
          w_state_n = BREAK;
        end else
`endif
        if (tx_valid) begin
          w_state_n    = START;
          w_s_n        = '0;
          w_shreg_n    = tx_data;
          w_data_n     = tx_data;
          w_par_n      = parity_t'(parity_mode);
          w_stop_n     = stop_t'(stop_mode);
          w_brk_stop_n = 1'b0;
        end
      end
      START: begin
        if (w_tick) begin
          if (w_bit_last) begin
            w_state_n = DATA;
            w_s_n     = '0;
            w_n_n     = '0;
          end else begin
            w_s_n = r_s + 1'b1;
          end
        end
      end
      DATA: begin
        if (w_tick) begin
          if (w_bit_last) begin
            w_s_n     = '0;
            w_shreg_n = r_shreg >> 1;
            if (r_n == NW'(DBIT - 1)) begin
              w_state_n = ((r_par == PAR_EVEN) || (r_par == PAR_ODD)) ? PARITY : STOP;
            end else begin
              w_n_n = r_n + 1'b1;
            end
          end else begin
            w_s_n = r_s + 1'b1;
          end
        end
      end
      PARITY: begin
        if (w_tick) begin
          if (w_bit_last) begin
            w_state_n = STOP;
            w_s_n     = '0;
          end else begin
            w_s_n = r_s + 1'b1;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (w_stop_last) begin
            w_state_n = IDLE;
            w_s_n     = '0;
            w_done_n  = !r_brk_stop;
          end else begin
            w_s_n = r_s + 1'b1;
          end
        end
      end
      BREAK: begin
`ifdef UART_TX_BREAK_EN
        // Leaving a break reuses STOP as a single stop bit with the done pulse suppressed.
        if (!brk) begin
          w_state_n    = STOP;
          w_s_n        = '0;
          w_stop_n     = STOP_1;
          w_brk_stop_n = 1'b1;
        end
`else
        w_state_n = IDLE;
`endif
      end
      default: w_state_n = IDLE;
    endcase

    // Pin value is derived from the next state so the registered output lines up with it.
    case (w_state_n)
      START:   w_tx_n = 1'b0;
      DATA:    w_tx_n = w_shreg_n[0];
      PARITY:  w_tx_n = w_par_bit;
      BREAK:   w_tx_n = 1'b0;
      default: w_tx_n = 1'b1;
    endcase
  end

  // State, datapath and registered output update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_s        <= '0;
      r_n        <= '0;
      r_shreg    <= '0;
      r_data     <= '0;
      r_par      <= PAR_NONE;
      r_stop     <= STOP_1;
      r_brk_stop <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_s        <= w_s_n;
      r_n        <= w_n_n;
      r_shreg    <= w_shreg_n;
      r_data     <= w_data_n;
      r_par      <= w_par_n;
      r_stop     <= w_stop_n;
      r_brk_stop <= w_brk_stop_n;
      r_tx       <= w_tx_n;
      r_busy     <= (w_state_n != IDLE);
      r_done     <= w_done_n;
    end
  end

  assign tx_ready     = (r_state == IDLE);
  assign tx           = r_tx;
  assign tx_busy      = r_busy;
  assign tx_done_tick = r_done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed self-checking bench for uart_tx_cfg (DBIT=8, OVERSAMPLE=16).
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        brk;
  logic [10:0] dvsr;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic [1:0]  parity_mode;
  logic [1:0]  stop_mode;
  logic        tx;
  logic        tx_busy;
  logic        tx_done_tick;

  int checks   = 0;
  int failures = 0;

  logic cap_tx  [0:2047];
  logic cap_dn  [0:2047];
  logic cap_rdy [0:2047];
  int   done_at;
  int   done_cnt;

  always #5 clk = ~clk;

  uart_tx_cfg #(
    .DBIT      (8),
    .OVERSAMPLE(16),
    .DVSR_W    (11)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef UART_TX_BREAK_EN
    .brk         (brk),
`endif
    .dvsr        (dvsr),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .parity_mode (parity_mode),
    .stop_mode   (stop_mode),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .tx_done_tick(tx_done_tick)
  );

  // Expected line level i clocks after the accept edge (L = clocks per bit).
  function automatic logic exp_bit(input logic [7:0] d, input logic [1:0] pm,
                                   input int L, input int i);
    if (i < L) return 1'b0;
    if (i < 9 * L) return d[(i - L) / L];
    if ((pm == 2'b01) && (i < 10 * L)) return ^d;
    if ((pm == 2'b10) && (i < 10 * L)) return ~^d;
    return 1'b1;
  endfunction

  // Launch one frame and record tx/done/ready per clock until two clocks past the done pulse.
  task automatic capture(input logic [7:0] d, input logic [1:0] pm, input logic [1:0] sm,
                         input int maxc);
    done_at  = -1;
    done_cnt = 0;
    tx_data     = d;
    parity_mode = pm;
    stop_mode   = sm;
    tx_valid    = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      cap_tx[i]  = tx;
      cap_dn[i]  = tx_done_tick;
      cap_rdy[i] = tx_ready;
      if (tx_done_tick) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      if ((done_at >= 0) && (i == done_at + 2)) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
    checks++; if (tx_done_tick !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", tx_done_tick); end
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", tx_ready); end
    tx_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk); #1;
    checks++; if ((tx !== 1'b1) || (tx_busy !== 1'b0)) begin
      failures++; $display("FAIL idle_after_reset tx=%b busy=%b exp tx=1 busy=0", tx, tx_busy);
    end
  endtask

  task automatic test_8n1();
    logic [7:0] d = 8'hA5;
    capture(d, 2'b00, 2'b00, 400);
    for (int i = 0; i <= 160; i++) begin
      checks++;
      if (cap_tx[i] !== exp_bit(d, 2'b00, 16, i)) begin
        failures++; $display("FAIL 8n1_tx[%0d] got=%b exp=%b", i, cap_tx[i], exp_bit(d, 2'b00, 16, i));
      end
    end
    checks++; if (done_at != 160) begin failures++; $display("FAIL 8n1_done_at got=%0d exp=160", done_at); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL 8n1_done_cnt got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_parity();
    logic [7:0] d;
    logic [1:0] pms [3]   = '{2'b01, 2'b10, 2'b00};
    logic [7:0] ds  [3]   = '{8'h07, 8'h07, 8'h00};
    logic       pbit [3]  = '{1'b1, 1'b0, 1'b1};
    int         dexp [3]  = '{176, 176, 160};
    for (int k = 0; k < 3; k++) begin
      d = ds[k];
      capture(d, pms[k], 2'b00, 400);
      checks++; if (done_at != dexp[k]) begin
        failures++; $display("FAIL parity%0d_done_at got=%0d exp=%0d", k, done_at, dexp[k]);
      end
      checks++; if (cap_tx[152] !== pbit[k]) begin
        failures++; $display("FAIL parity%0d_bit got=%b exp=%b", k, cap_tx[152], pbit[k]);
      end
      for (int i = 0; i < dexp[k]; i += 4) begin
        checks++;
        if (cap_tx[i] !== exp_bit(d, pms[k], 16, i)) begin
          failures++; $display("FAIL parity%0d_tx[%0d] got=%b exp=%b", k, i, cap_tx[i], exp_bit(d, pms[k], 16, i));
        end
      end
    end
  endtask

  task automatic test_stop();
    logic [1:0] sms  [2] = '{2'b01, 2'b10};
    int         dexp [2] = '{168, 176};
    for (int k = 0; k < 2; k++) begin
      capture(8'hFF, 2'b00, sms[k], 400);
      checks++; if (done_at != dexp[k]) begin
        failures++; $display("FAIL stop%0d_done_at got=%0d exp=%0d", k, done_at, dexp[k]);
      end
      checks++; if (done_cnt != 1) begin
        failures++; $display("FAIL stop%0d_done_cnt got=%0d exp=1", k, done_cnt);
      end
      checks++; if ((cap_tx[143] !== 1'b1) || (cap_tx[dexp[k] - 1] !== 1'b1)) begin
        failures++; $display("FAIL stop%0d_level got=%b%b exp=11", k, cap_tx[143], cap_tx[dexp[k] - 1]);
      end
      checks++; if (cap_dn[dexp[k] + 1] !== 1'b0) begin
        failures++; $display("FAIL stop%0d_pulse_width got=%b exp=0", k, cap_dn[dexp[k] + 1]);
      end
    end
    // Preceding data bit of 0xFF is 1 too; check the stop bit against a 0 data bit instead.
    capture(8'h00, 2'b00, 2'b01, 400);
    checks++; if ((cap_tx[143] !== 1'b0) || (cap_tx[144] !== 1'b1) || (cap_tx[167] !== 1'b1)) begin
      failures++; $display("FAIL stop15_edges got=%b%b%b exp=011", cap_tx[143], cap_tx[144], cap_tx[167]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d1 = 8'h55;
    logic [7:0] d2 = 8'hAA;
    int first_done  = -1;
    int second_done = -1;
    int rdy_cnt     = 0;
    tx_data     = d1;
    parity_mode = 2'b00;
    stop_mode   = 2'b00;
    tx_valid    = 1'b1;
    @(posedge clk); #1;
    tx_data = d2;
    for (int i = 0; i <= 330; i++) begin
      cap_tx[i]  = tx;
      cap_rdy[i] = tx_ready;
      if (tx_done_tick) begin
        if (first_done < 0) first_done = i;
        else if (second_done < 0) second_done = i;
      end
      if ((i <= 320) && tx_ready) rdy_cnt++;
      if (i == 161) tx_valid = 1'b0;
      @(posedge clk); #1;
    end
    checks++; if (first_done != 160) begin failures++; $display("FAIL b2b_done1 got=%0d exp=160", first_done); end
    checks++; if (second_done != 321) begin failures++; $display("FAIL b2b_done2 got=%0d exp=321", second_done); end
    checks++; if ((cap_tx[160] !== 1'b1) || (cap_rdy[160] !== 1'b1)) begin
      failures++; $display("FAIL b2b_idle_gap tx=%b rdy=%b exp 1 1", cap_tx[160], cap_rdy[160]);
    end
    checks++; if ((cap_tx[161] !== 1'b0) || (cap_rdy[161] !== 1'b0)) begin
      failures++; $display("FAIL b2b_second_start tx=%b rdy=%b exp 0 0", cap_tx[161], cap_rdy[161]);
    end
    checks++; if (rdy_cnt != 1) begin failures++; $display("FAIL b2b_ready_cycles got=%0d exp=1", rdy_cnt); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (cap_tx[24 + 16 * k] !== d1[k]) begin
        failures++; $display("FAIL b2b_f1_bit%0d got=%b exp=%b", k, cap_tx[24 + 16 * k], d1[k]);
      end
      checks++; if (cap_tx[185 + 16 * k] !== d2[k]) begin
        failures++; $display("FAIL b2b_f2_bit%0d got=%b exp=%b", k, cap_tx[185 + 16 * k], d2[k]);
      end
    end
  endtask

  task automatic test_dvsr_reset();
    logic [7:0] d = 8'hA5;
    logic saw_done = 1'b0;
    logic saw_low  = 1'b0;
    dvsr = 11'd3;
    capture(d, 2'b00, 2'b00, 800);
    checks++; if (done_at != 640) begin failures++; $display("FAIL dvsr3_done_at got=%0d exp=640", done_at); end
    checks++; if ((cap_tx[63] !== 1'b0) || (cap_tx[64] !== 1'b1)) begin
      failures++; $display("FAIL dvsr3_start_len got=%b%b exp=01", cap_tx[63], cap_tx[64]);
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (cap_tx[64 * k + 32] !== exp_bit(d, 2'b00, 64, 64 * k + 32)) begin
        failures++; $display("FAIL dvsr3_bit%0d got=%b exp=%b", k, cap_tx[64 * k + 32], exp_bit(d, 2'b00, 64, 64 * k + 32));
      end
    end
    // Mid-frame reset: bit 0 of 0xA4 is low so the forced return to 1 is visible.
    tx_data  = 8'hA4;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    for (int i = 1; i <= 99; i++) begin
      @(posedge clk); #1;
    end
    checks++; if (tx !== 1'b0) begin failures++; $display("FAIL rst_mid_pre_tx got=%b exp=0", tx); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if ((tx !== 1'b1) || (tx_busy !== 1'b0) || (tx_ready !== 1'b1)) begin
      failures++; $display("FAIL rst_mid_abort tx=%b busy=%b rdy=%b exp 1 0 1", tx, tx_busy, tx_ready);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 700; i++) begin
      @(posedge clk); #1;
      if (tx_done_tick) saw_done = 1'b1;
      if (!tx) saw_low = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL rst_mid_no_done got=%b exp=0", saw_done); end
    checks++; if (saw_low !== 1'b0) begin failures++; $display("FAIL rst_mid_line_idle got_low=%b exp=0", saw_low); end
    dvsr = 11'd0;
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    int   low_cnt  = 0;
    logic saw_done = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    brk      = 1'b1;
    for (int i = 0; i <= 520; i++) begin
      @(posedge clk); #1;
      cap_tx[i]  = tx;
      cap_rdy[i] = tx_ready;
      if (!tx) low_cnt++;
      if (tx_done_tick) saw_done = 1'b1;
      if (i == 499) brk = 1'b0;
      if (i == 505) tx_valid = 1'b0;
    end
    checks++; if (low_cnt != 500) begin failures++; $display("FAIL brk_low_len got=%0d exp=500", low_cnt); end
    checks++; if ((cap_tx[500] !== 1'b1) || (cap_tx[515] !== 1'b1) || (cap_rdy[515] !== 1'b0)) begin
      failures++; $display("FAIL brk_stop tx=%b%b rdy=%b exp 11 0", cap_tx[500], cap_tx[515], cap_rdy[515]);
    end
    checks++; if (cap_rdy[516] !== 1'b1) begin failures++; $display("FAIL brk_ready_back got=%b exp=1", cap_rdy[516]); end
    checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL brk_no_done got=%b exp=0", saw_done); end
  endtask
`endif

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog timeout");
    $fatal(1, "TB_RESULT checks=%0d failures=%0d", checks, failures);
  end

  initial begin
    rst_n       = 1'b0;
    brk         = 1'b0;
    dvsr        = 11'd0;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    parity_mode = 2'b00;
    stop_mode   = 2'b00;
    test_reset();
    test_8n1();
    test_parity();
    test_stop();
    test_back_to_back();
    test_dvsr_reset();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
